// File: rtl/uart_trace_pkg.sv
// Shared constants, FSM state type and helpers for the multi-channel UART trace formatter.
package uart_trace_pkg;

    localparam logic [7:0] ASCII_R   = 8'h52;
    localparam logic [7:0] ASCII_COL = 8'h3A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_R,
        ST_HDR_CH,
        ST_HDR_COL,
        ST_DATA,
        ST_EOL_CR,
        ST_EOL_LF
    } fmt_state_e;

    // Hex digits needed for a DW-bit data word.
    function automatic int calc_nib(input int dw);
        return (dw + 3) / 4;
    endfunction

    // Hex digits needed for a channel index; a single channel still prints "0".
    function automatic int calc_chd(input int num_ch);
        int bits;
        bits = $clog2(num_ch);
        return (bits < 1) ? 1 : (bits + 3) / 4;
    endfunction

    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/uart_trace_fmt_if.sv
// Ready/valid byte stream from the trace formatter to the UART transmitter.
interface uart_trace_fmt_if;

    logic [7:0] o_byte;
    logic       o_byte_valid;
    logic       i_byte_ready;

    modport master (output o_byte, output o_byte_valid, input  i_byte_ready);
    modport slave  (input  o_byte, input  o_byte_valid, output i_byte_ready);

endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with a registered head; a write into an empty FIFO shows up one cycle later.
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr,
    input  logic [7:0]             din,
    output logic                   full,
    input  logic                   rd,
    output logic [7:0]             dout,
    output logic                   valid,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] cnt
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_q;
    logic          valid_q;
    logic [7:0]    head_q;
    logic          wr_en;
    logic          rd_en;
    logic          load;

    // cnt_q counts the head register too, so the array only holds cnt_q - valid_q bytes.
    assign wr_en = wr & ~full;
    assign rd_en = rd & valid_q;
    assign load  = (cnt_q > {{AW{1'b0}}, valid_q}) & (~valid_q | rd_en);

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);
    assign cnt   = cnt_q;
    assign dout  = head_q;
    assign valid = valid_q;

    // NOTE: the storage array has no reset; only pointers, count and head are reset,
    // which keeps it a plain RAM and is safe because nothing reads an unwritten slot.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (load) begin
                head_q  <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
                valid_q <= 1'b1;
            end else if (rd_en) begin
                valid_q <= 1'b0;
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_trace_fmt.sv
// Captures strobed words from NUM_CH channels, arbitrates round-robin and formats each
// as "R<ch>:<hex>" plus line ending into a byte FIFO feeding the UART transmitter.
module uart_trace_fmt
    import uart_trace_pkg::*;
#(
    parameter int DW         = 32,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int EOL_MODE   = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           i_ch_stb,
    input  logic [NUM_CH*DW-1:0]        i_ch_data,
    output logic [NUM_CH-1:0]           o_ch_pend,
    output logic [NUM_CH-1:0]           o_ch_ovf,
    input  logic                        i_ovf_clr,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_cnt,
    uart_trace_fmt_if.master            tx
);

    localparam int         NIB      = calc_nib(DW);
    localparam int         CHD      = calc_chd(NUM_CH);
    localparam int         CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int         DSW      = NIB * 4;
    localparam int         CSW      = CHD * 4;
    localparam logic [3:0] NIB_LAST = 4'(NIB - 1);
    localparam logic [3:0] CHD_LAST = 4'(CHD - 1);

    logic [DW-1:0]     data_q [NUM_CH];
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] gnt_vec;
    logic [CW-1:0]     gnt_ch;
    logic [CW-1:0]     idx;
    logic              gnt_any;
    logic              grant;

    fmt_state_e        state_q, state_d;
    logic [DSW-1:0]    sh_q, sh_d;
    logic [CSW-1:0]    ch_sh_q, ch_sh_d;
    logic [CW-1:0]     last_q, last_d;
    logic [3:0]        dig_q, dig_d;

    logic              fifo_wr;
    logic [7:0]        fifo_din;
    logic              fifo_full;
    logic              fifo_empty;

    // First pending channel after the last-served one, wrapping round.
    // NOTE: every variable written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = '0;
        idx     = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CW'((int'(last_q) + i) % NUM_CH);
            if (!gnt_any && pend_q[idx]) begin
                gnt_any = 1'b1;
                gnt_ch  = idx;
            end
        end
    end

    assign grant = (state_q == ST_IDLE) & gnt_any;

    always_comb begin
        gnt_vec = '0;
        for (int c = 0; c < NUM_CH; c++) gnt_vec[c] = grant && (gnt_ch == CW'(c));
    end

    // A strobe in the grant cycle of its own channel is accepted: the grant takes the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ovf_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) data_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (i_ch_stb[c] && (!pend_q[c] || gnt_vec[c])) begin
                    data_q[c] <= i_ch_data[c*DW +: DW];
                    pend_q[c] <= 1'b1;
                end else if (gnt_vec[c]) begin
                    pend_q[c] <= 1'b0;
                end
                if (i_ch_stb[c] && pend_q[c] && !gnt_vec[c]) ovf_q[c] <= 1'b1;
                else if (i_ovf_clr)                          ovf_q[c] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            ch_sh_q <= '0;
            last_q  <= CW'(NUM_CH - 1);
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            ch_sh_q <= ch_sh_d;
            last_q  <= last_d;
            dig_q   <= dig_d;
        end
    end

    // Each non-idle state emits one byte and advances only when the FIFO takes it.
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        ch_sh_d  = ch_sh_q;
        last_d   = last_q;
        dig_d    = dig_q;
        fifo_wr  = 1'b0;
        fifo_din = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    sh_d    = DSW'(data_q[gnt_ch]);
                    ch_sh_d = CSW'(gnt_ch);
                    last_d  = gnt_ch;
                    dig_d   = '0;
                    state_d = ST_HDR_R;
                end
            end
            ST_HDR_R: begin
                fifo_wr  = !fifo_full;
                fifo_din = ASCII_R;
                if (fifo_wr) state_d = ST_HDR_CH;
            end
            ST_HDR_CH: begin
                fifo_wr  = !fifo_full;
                fifo_din = nib2ascii(ch_sh_q[CSW-1 -: 4]);
                if (fifo_wr) begin
                    ch_sh_d = ch_sh_q << 4;
                    if (dig_q == CHD_LAST) begin
                        dig_d   = '0;
                        state_d = ST_HDR_COL;
                    end else begin
                        dig_d = dig_q + 4'd1;
                    end
                end
            end
            ST_HDR_COL: begin
                fifo_wr  = !fifo_full;
                fifo_din = ASCII_COL;
                if (fifo_wr) state_d = ST_DATA;
            end
            ST_DATA: begin
                fifo_wr  = !fifo_full;
                fifo_din = nib2ascii(sh_q[DSW-1 -: 4]);
                if (fifo_wr) begin
                    sh_d = sh_q << 4;
                    if (dig_q == NIB_LAST) begin
                        dig_d   = '0;
                        state_d = (EOL_MODE != 0) ? ST_EOL_LF : ST_EOL_CR;
                    end else begin
                        dig_d = dig_q + 4'd1;
                    end
                end
            end
            ST_EOL_CR: begin
                fifo_wr  = !fifo_full;
                fifo_din = ASCII_CR;
                if (fifo_wr) state_d = ST_EOL_LF;
            end
            ST_EOL_LF: begin
                fifo_wr  = !fifo_full;
                fifo_din = ASCII_LF;
                if (fifo_wr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (fifo_wr),
        .din   (fifo_din),
        .full  (fifo_full),
        .rd    (tx.o_byte_valid & tx.i_byte_ready),
        .dout  (tx.o_byte),
        .valid (tx.o_byte_valid),
        .empty (fifo_empty),
        .cnt   (o_fifo_cnt)
    );

    assign o_ch_pend = pend_q;
    assign o_ch_ovf  = ovf_q;
    assign o_busy    = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_trace_fmt.sv
// Directed bench: default 4-channel formatter plus two single-channel, LF-only variants.
module tb_uart_trace_fmt;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default configuration: DW=32, NUM_CH=4, FIFO_DEPTH=16, CRLF.
    logic [3:0]   stb_a;
    logic [127:0] data_a;
    logic [3:0]   pend_a;
    logic [3:0]   ovf_a;
    logic         clr_a;
    logic         busy_a;
    logic [4:0]   cnt_a;
    uart_trace_fmt_if tx_a ();

    // Variant B: DW=12, NUM_CH=1, LF only.
    logic         stb_b;
    logic [11:0]  data_b;
    logic         pend_b;
    logic         ovf_b;
    logic         busy_b;
    logic [4:0]   cnt_b;
    uart_trace_fmt_if tx_b ();

    // Variant C: DW=10, NUM_CH=1, LF only.
    logic         stb_c;
    logic [9:0]   data_c;
    logic         pend_c;
    logic         ovf_c;
    logic         busy_c;
    logic [4:0]   cnt_c;
    uart_trace_fmt_if tx_c ();

    logic         clr_bc;

    uart_trace_fmt dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ch_stb   (stb_a),
        .i_ch_data  (data_a),
        .o_ch_pend  (pend_a),
        .o_ch_ovf   (ovf_a),
        .i_ovf_clr  (clr_a),
        .o_busy     (busy_a),
        .o_fifo_cnt (cnt_a),
        .tx         (tx_a)
    );

    uart_trace_fmt #(.DW(12), .NUM_CH(1), .FIFO_DEPTH(16), .EOL_MODE(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ch_stb   (stb_b),
        .i_ch_data  (data_b),
        .o_ch_pend  (pend_b),
        .o_ch_ovf   (ovf_b),
        .i_ovf_clr  (clr_bc),
        .o_busy     (busy_b),
        .o_fifo_cnt (cnt_b),
        .tx         (tx_b)
    );

    uart_trace_fmt #(.DW(10), .NUM_CH(1), .FIFO_DEPTH(16), .EOL_MODE(1)) dut_c (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ch_stb   (stb_c),
        .i_ch_data  (data_c),
        .o_ch_pend  (pend_c),
        .o_ch_ovf   (ovf_c),
        .i_ovf_clr  (clr_bc),
        .o_busy     (busy_c),
        .o_fifo_cnt (cnt_c),
        .tx         (tx_c)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] q_c[$];

    // Inputs only change just after a rising edge, so a byte seen valid&ready here is taken.
    always @(negedge clk) begin
        if (tx_a.o_byte_valid && tx_a.i_byte_ready) q_a.push_back(tx_a.o_byte);
        if (tx_b.o_byte_valid && tx_b.i_byte_ready) q_b.push_back(tx_b.o_byte);
        if (tx_c.o_byte_valid && tx_c.i_byte_ready) q_c.push_back(tx_c.o_byte);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_a(input int ch, input logic [31:0] d);
        data_a[ch*32 +: 32] = d;
        stb_a[ch] = 1'b1;
        tick();
        stb_a = '0;
    endtask

    function automatic logic [7:0] pop_byte(input int which);
        logic [7:0] b;
        b = 8'hxx;
        case (which)
            0:       if (q_a.size() > 0) b = q_a.pop_front();
            1:       if (q_b.size() > 0) b = q_b.pop_front();
            default: if (q_c.size() > 0) b = q_c.pop_front();
        endcase
        return b;
    endfunction

    // Waits until the chosen DUT has nothing pending and its stream has drained.
    task automatic wait_idle(input int which);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        repeat (2) tick();
        while (!done && n < 2000) begin
            case (which)
                0:       done = !busy_a && (pend_a == '0);
                1:       done = !busy_b && !pend_b;
                default: done = !busy_c && !pend_c;
            endcase
            if (!done) begin
                tick();
                n++;
            end
        end
        if (!done) check($sformatf("idle_timeout_%0d", which), {63'd0, done}, 64'd1);
    endtask

    task automatic check_line(input int which, input string tag, input string body, input bit crlf);
        logic [7:0] exp_q[$];
        for (int i = 0; i < body.len(); i++) exp_q.push_back(body[i]);
        if (crlf) exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s[%0d]", tag, i), {56'd0, pop_byte(which)}, {56'd0, exp_q[i]});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        q_a.delete();
        q_b.delete();
        q_c.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        stb_a  = '0;
        data_a = '0;
        clr_a  = 1'b0;
        stb_b  = 1'b0;
        data_b = '0;
        stb_c  = 1'b0;
        data_c = '0;
        clr_bc = 1'b0;
        tx_a.i_byte_ready = 1'b1;
        tx_b.i_byte_ready = 1'b1;
        tx_c.i_byte_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_valid", {63'd0, tx_a.o_byte_valid}, 64'd0);
        check("rst_byte",  {56'd0, tx_a.o_byte},       64'd0);
        check("rst_cnt",   {59'd0, cnt_a},             64'd0);
        check("rst_busy",  {63'd0, busy_a},            64'd0);
        check("rst_pend",  {60'd0, pend_a},            64'd0);
        check("rst_ovf",   {60'd0, ovf_a},             64'd0);
        rst_n = 1'b1;
        tick();

        // 1: single line on channel 2
        strobe_a(2, 32'hDEADBEEF);
        check("t1_pend_set", {63'd0, pend_a[2]}, 64'd1);
        tick();
        check("t1_pend_clr_at_grant", {63'd0, pend_a[2]}, 64'd0);
        check("t1_busy", {63'd0, busy_a}, 64'd1);
        wait_idle(0);
        check_line(0, "t1", "R2:DEADBEEF", 1'b1);
        check("t1_busy_done", {63'd0, busy_a}, 64'd0);

        // 2: backpressure, one line fits, the second stalls at full
        tx_a.i_byte_ready = 1'b0;
        strobe_a(0, 32'h01234567);
        repeat (50) tick();
        check("t2_cnt_one_line", {59'd0, cnt_a}, 64'd13);
        check("t2_valid_held", {63'd0, tx_a.o_byte_valid}, 64'd1);
        strobe_a(1, 32'h89ABCDEF);
        repeat (50) tick();
        check("t2_cnt_full", {59'd0, cnt_a}, 64'd16);
        check("t2_busy_stalled", {63'd0, busy_a}, 64'd1);
        check("t2_no_bytes_taken", q_a.size(), 64'd0);
        tx_a.i_byte_ready = 1'b1;
        wait_idle(0);
        check_line(0, "t2a", "R0:01234567", 1'b1);
        check_line(0, "t2b", "R1:89ABCDEF", 1'b1);

        // 3: round-robin from a fresh pointer, ch0 re-strobed during ch1's line
        do_reset();
        for (int c = 0; c < 4; c++) data_a[c*32 +: 32] = 32'(c);
        stb_a = 4'hF;
        tick();
        stb_a = '0;
        n = 0;
        while (q_a.size() < 15 && n < 500) begin
            tick();
            n++;
        end
        if (q_a.size() < 15) check("t3_wait_bytes", q_a.size(), 64'd15);
        strobe_a(0, 32'h00000004);
        wait_idle(0);
        check_line(0, "t3_0", "R0:00000000", 1'b1);
        check_line(0, "t3_1", "R1:00000001", 1'b1);
        check_line(0, "t3_2", "R2:00000002", 1'b1);
        check_line(0, "t3_3", "R3:00000003", 1'b1);
        check_line(0, "t3_4", "R0:00000004", 1'b1);

        // 4: dropped strobe; the drop also beats a same-cycle clear
        strobe_a(0, 32'h00000001);
        strobe_a(1, 32'h0000AAAA);
        data_a[32 +: 32] = 32'h0000BBBB;
        stb_a[1] = 1'b1;
        clr_a = 1'b1;
        tick();
        stb_a = '0;
        clr_a = 1'b0;
        check("t4_ovf_set", {60'd0, ovf_a}, 64'h2);
        check("t4_pend1", {63'd0, pend_a[1]}, 64'd1);
        wait_idle(0);
        check_line(0, "t4_0", "R0:00000001", 1'b1);
        check_line(0, "t4_1", "R1:0000AAAA", 1'b1);
        check("t4_ovf_sticky", {60'd0, ovf_a}, 64'h2);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("t4_ovf_clr", {60'd0, ovf_a}, 64'd0);

        // 5: strobe in its own grant cycle keeps pend, then reset mid-line
        strobe_a(3, 32'h12345678);
        strobe_a(3, 32'h11111111);
        check("t5_stb_at_grant_pend", {63'd0, pend_a[3]}, 64'd1);
        strobe_a(3, 32'h22222222);
        check("t5_ovf3", {60'd0, ovf_a}, 64'h8);
        repeat (3) tick();
        check("t5_busy_mid_line", {63'd0, busy_a}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {63'd0, tx_a.o_byte_valid}, 64'd0);
        check("t5_rst_cnt",   {59'd0, cnt_a},             64'd0);
        check("t5_rst_pend",  {60'd0, pend_a},            64'd0);
        check("t5_rst_ovf",   {60'd0, ovf_a},             64'd0);
        check("t5_rst_busy",  {63'd0, busy_a},            64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        q_a.delete();
        strobe_a(0, 32'h00000005);
        wait_idle(0);
        check_line(0, "t5", "R0:00000005", 1'b1);

        // 6: narrow single-channel variants with LF endings
        data_b = 12'hABC;
        stb_b  = 1'b1;
        data_c = 10'h3FF;
        stb_c  = 1'b1;
        tick();
        stb_b = 1'b0;
        stb_c = 1'b0;
        wait_idle(1);
        wait_idle(2);
        check_line(1, "t6b", "R0:ABC", 1'b0);
        check_line(2, "t6c", "R0:3FF", 1'b0);
        data_b = 12'h00F;
        stb_b  = 1'b1;
        tick();
        stb_b = 1'b0;
        wait_idle(1);
        check_line(1, "t6b_lead0", "R0:00F", 1'b0);

        check("end_q_a_empty", q_a.size(), 64'd0);
        check("end_q_b_empty", q_b.size(), 64'd0);
        check("end_q_c_empty", q_c.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
